fifo_burst_drainer: RTL



---
 rtl/fifo_burst_drainer_pkg.sv | 5 +
 rtl/fifo_burst_drainer_if.sv | 19 +
 rtl/fifo_burst_drainer_skid_buf.sv | 27 ++
 rtl/fifo_burst_drainer.sv | 72 +++++++
 4 files changed

// File: rtl/fifo_burst_drainer_pkg.sv
// fifo_burst_drainer_pkg: shared data width and drainer state encoding
package fifo_burst_drainer_pkg;
  localparam int FIFO_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
endpackage

// File: rtl/fifo_burst_drainer_if.sv
// fifo_burst_drainer_if: FIFO read port plus the framed output stream
interface fifo_burst_drainer_if #(parameter int W = fifo_burst_drainer_pkg::FIFO_WIDTH);
  logic fifo_rd_en;
  logic [W-1:0] fifo_data_out;
  logic fifo_empty;
  logic fifo_underflow;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  modport master (
    output fifo_rd_en, out_data, out_valid, out_last,
    input fifo_data_out, fifo_empty, fifo_underflow, out_ready
  );
  modport slave (
    input fifo_rd_en, out_data, out_valid, out_last,
    output fifo_data_out, fifo_empty, fifo_underflow, out_ready
  );
endinterface

// File: rtl/fifo_burst_drainer_skid_buf.sv
// burst_skid_buf: two-entry {data,last} buffer; head is always entry 0
module burst_skid_buf #(parameter int W = 16) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [W:0] push_entry,
  input  logic       pop,
  output logic [W:0] head,
  output logic [1:0] cnt,
  output logic       empty
);
  logic [W:0] tail;
  logic p;
  assign p = pop && cnt != 2'd0;
  assign empty = cnt == 2'd0;
  always_ff @(posedge clk)
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (p && cnt == 2'd2) head <= tail;
      else if (push && (cnt == 2'd0 || (p && cnt == 2'd1))) head <= push_entry;
      if (push && ((cnt == 2'd1 && !p) || (cnt == 2'd2 && p))) tail <= push_entry;
      cnt <= cnt + 2'(push) - 2'(p);
    end
endmodule

// File: rtl/fifo_burst_drainer.sv
// fifo_burst_drainer: pops FIFO words and re-emits them as gap-separated fixed-length bursts
module fifo_burst_drainer #(
  parameter int FIFO_WIDTH = fifo_burst_drainer_pkg::FIFO_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fifo_burst_drainer_if.master bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_cnt,
  output logic [CNT_WIDTH-1:0] underflow_cnt
);
  import fifo_burst_drainer_pkg::*;
  state_t state;
  logic [7:0] issued, accepted, gap_cnt;
  logic inflight, push, drop, hs, buf_empty;
  logic [1:0] buf_cnt;
  logic [FIFO_WIDTH:0] head;
  assign push = inflight && !bus.fifo_underflow;
  assign drop = inflight && bus.fifo_underflow;
  assign hs = bus.out_valid && bus.out_ready;
  // two credits: buffered words plus the read still in flight
  assign bus.fifo_rd_en = state == BURST && en && !bus.fifo_empty &&
                          buf_cnt + 2'(inflight) < 2'd2 && issued < 8'(BURST_LEN);
  assign bus.out_valid = !buf_empty;
  assign bus.out_data = head[FIFO_WIDTH:1];
  assign bus.out_last = head[0] && !buf_empty;
  assign busy = state != IDLE || inflight || !buf_empty;
  burst_skid_buf #(.W(FIFO_WIDTH)) u_buf (
    .clk,
    .rst,
    .push,
    .push_entry({bus.fifo_data_out, accepted == 8'(BURST_LEN - 1)}),
    .pop(hs),
    .head,
    .cnt(buf_cnt),
    .empty(buf_empty)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      issued <= '0;
      accepted <= '0;
      gap_cnt <= '0;
      inflight <= 1'b0;
      words_cnt <= '0;
      underflow_cnt <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      issued <= issued + 8'(bus.fifo_rd_en) - 8'(drop);
      if (push) accepted <= accepted + 8'd1;
      if (hs && !(&words_cnt)) words_cnt <= words_cnt + 1'b1;
      if (drop && !(&underflow_cnt)) underflow_cnt <= underflow_cnt + 1'b1;
      case (state)
        IDLE: if (en && !bus.fifo_empty) begin
          state <= BURST;
          issued <= '0;
          accepted <= '0;
        end
        BURST: if (hs && bus.out_last) begin
          state <= GAP_CYCLES == 0 ? IDLE : GAP;
          gap_cnt <= '0;
        end
        GAP: if (gap_cnt == 8'(GAP_CYCLES - 1)) state <= IDLE;
             else gap_cnt <= gap_cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
endmodule
